adc16dv160_capture_ctrl: RTL and testbench
==========================================

ADC16DV160_CAPTURE_CTRL -- requirements
Module: adc16dv160_capture_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, AXI-Stream data width in bits (DW multiple of 8).
REQ-002 SHALL have port ACLK  in  1  single clock for all logic.
REQ-003 SHALL have port ARESETN  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  in  1  capture request, level-sampled each ACLK cycle.
REQ-005 SHALL have port test  in  1  1 = counting test pattern, 0 = ADC samples.
REQ-006 SHALL have port dsize  in  32  packet length in DW-bit beats.
REQ-007 SHALL have port fifo_dout  in  DW  head word of first-word-fall-through sample FIFO.
REQ-008 SHALL have port fifo_empty  in  1  sample FIFO empty.
REQ-009 SHALL have port fifo_full  in  1  sample FIFO full.
REQ-010 SHALL have port fifo_rd_en  out  1  pop FIFO head.
REQ-011 SHALL have ports m00_axis_tvalid/tdata[DW]/tkeep[DW/8]/tlast  out, m00_axis_tready  in: AXI-Stream master.
REQ-012 SHALL have port sr_busy  out  1  capture in progress.
REQ-013 SHALL have port sr_pc  out  1  packet complete, sticky.

Function
REQ-014 SHALL implement states IDLE, RUN, FLUSH.
REQ-015 IDLE->RUN SHALL occur when start=1 and dsize!=0; dsize and test latched that cycle; beat counter cleared; sr_pc cleared.
REQ-016 start with dsize=0 SHALL be ignored (stay IDLE, sr_pc unchanged).
REQ-017 start while in RUN or FLUSH SHALL be ignored; latched dsize/test stay constant for the packet.
REQ-018 Output SHALL use one registered beat stage; stage loads when empty or m00_axis_tready=1 with tvalid=1.
REQ-019 In RUN with test=0: fifo_rd_en = !fifo_empty & stage-loadable (combinational); loaded tdata = fifo_dout; no pop when fifo_empty.
REQ-020 In RUN with test=1: FIFO SHALL never be popped; loaded tdata = beat index (0,1,2,...) zero-extended to DW; one beat per loadable cycle.
REQ-021 Beat counter SHALL increment on each load; load of beat index dsize-1 SHALL set tlast=1 on that beat and transition RUN->FLUSH.
REQ-022 tdata, tlast SHALL be held stable while tvalid=1 and tready=0; tvalid SHALL not drop without handshake.
REQ-023 m00_axis_tkeep SHALL be all ones.
REQ-024 FLUSH->IDLE SHALL occur on handshake of the tlast beat; sr_pc set same edge; sr_busy = state!=IDLE.
REQ-025 Load latency: FIFO word popped at edge N SHALL appear on tdata with tvalid=1 after edge N (one cycle).
REQ-026 Throughput: with FIFO non-empty and tready=1 continuously, one beat per cycle, no bubbles.
REQ-027 dsize counting SHALL be 32-bit unsigned; dsize=0xFFFFFFFF supported without wrap before tlast.

Reset
REQ-028 ARESETN=0 SHALL asynchronously force IDLE, tvalid=0, tlast=0, tdata=0, fifo_rd_en=0, sr_busy=0, sr_pc=0, counters=0.
REQ-029 Reset mid-packet SHALL abandon the packet; no tlast emitted; after release block waits in IDLE for new start.

Configuration
REQ-030 Macro ADC16DV160_CAPTURE_OVF_EN defined: add output ovf_cnt[15:0], increments each cycle fifo_full=1 while state=RUN, saturates at 0xFFFF, cleared on IDLE->RUN and on reset.
REQ-031 Macro ADC16DV160_CAPTURE_OVF_EN undefined: ovf_cnt port and logic absent; all other behaviour identical.

Verification
REQ-032 test=1, dsize=4, tready=1, start pulse -> tdata 0,1,2,3 on consecutive cycles, tlast on beat 3, sr_pc=1, fifo_rd_en never 1.
REQ-033 test=0, FIFO holds 0xA0..0xA7, dsize=8, tready toggling 1/0 -> exactly 8 pops, tdata 0xA0..0xA7 in order, held stable during tready=0, tlast on 0xA7.
REQ-034 dsize=0, start=1 -> remains IDLE, tvalid=0, sr_busy=0.
REQ-035 dsize=16, start re-asserted at beat 5 with dsize=2 -> ignored, 16 beats emitted, tlast on beat 15.
REQ-036 ARESETN low after 3 of 10 beats -> tvalid=0, sr_busy=0 immediately; subsequent start dsize=2 yields 2 beats starting at index 0.
REQ-037 OVF_EN build, fifo_full=1 for 5 cycles during RUN -> ovf_cnt=5; next start -> ovf_cnt=0.

Source files
------------

// File: rtl/adc16dv160_capture_ctrl_if.sv
// AXI-Stream bus bundle for the ADC16DV160 capture controller.
// Signals: tvalid/tdata/tkeep/tlast (master->slave), tready (slave->master).
// Parameter DW: data width in bits (multiple of 8).
interface adc16dv160_capture_ctrl_if #(
    parameter int unsigned DW = 32
) ();
    logic              tvalid;
    logic              tready;
    logic [DW-1:0]     tdata;
    logic [DW/8-1:0]   tkeep;
    logic              tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/adc16dv160_capture_ctrl.sv
// ADC16DV160 capture controller: turns a start request into one AXI-Stream
// packet of dsize beats, sourced from a FWFT sample FIFO or a counting pattern.
// Ports:
//   ACLK, ARESETN          clock, async active-low reset
//   start, test, dsize     capture request, pattern select, packet length (beats)
//   fifo_dout/empty/full   FWFT sample FIFO head and flags
//   fifo_rd_en             FIFO pop (combinational)
//   m00_axis               AXI-Stream master (interface, master modport)
//   sr_busy, sr_pc         capture in progress, sticky packet complete
//   ovf_cnt                FIFO-full cycle counter (only with ADC16DV160_CAPTURE_OVF_EN)
// Optional feature macro: ADC16DV160_CAPTURE_OVF_EN
module adc16dv160_capture_ctrl #(
    parameter int unsigned DW = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 start,
    input  logic                 test,
    input  logic [31:0]          dsize,
    input  logic [DW-1:0]        fifo_dout,
    input  logic                 fifo_empty,
    input  logic                 fifo_full,
    output logic                 fifo_rd_en,
    adc16dv160_capture_ctrl_if.master m00_axis,
    output logic                 sr_busy,
`ifdef ADC16DV160_CAPTURE_OVF_EN
    output logic [15:0]          ovf_cnt,
`endif
    output logic                 sr_pc
);

    localparam int unsigned KW = DW / 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [31:0]   dsize_q;
    logic [31:0]   beat_cnt;
    logic          test_q;
    logic [DW-1:0] tdata_q;
    logic          tvalid_q;
    logic          tlast_q;
    logic          sr_pc_q;
    logic          sr_busy_q;

    logic          stage_ready;
    logic          handshake;
    logic          last_beat;
    logic          go;
    logic          load;

    // Output stage can take a new beat when empty or being drained this cycle.
    assign stage_ready = !tvalid_q || m00_axis.tready;
    assign handshake   = tvalid_q && m00_axis.tready;
    assign last_beat   = (beat_cnt == (dsize_q - 32'd1));

    // Next-state, load and pop decode.
    always_comb begin
        state_nxt  = state;
        go         = 1'b0;
        load       = 1'b0;
        fifo_rd_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (dsize != 32'd0)) begin
                    go        = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                load       = stage_ready && (test_q || !fifo_empty);
                fifo_rd_en = stage_ready && !test_q && !fifo_empty;
                if (load && last_beat) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (handshake && tlast_q) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Packet parameters, beat counter, output stage and status flags.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            dsize_q   <= 32'd0;
            test_q    <= 1'b0;
            beat_cnt  <= 32'd0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            sr_pc_q   <= 1'b0;
            sr_busy_q <= 1'b0;
        end else begin
            if (go) begin
                dsize_q  <= dsize;
                test_q   <= test;
                beat_cnt <= 32'd0;
                sr_pc_q  <= 1'b0;
            end
            if (load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= test_q ? DW'(beat_cnt) : fifo_dout;
                tlast_q  <= last_beat;
                beat_cnt <= beat_cnt + 32'd1;
            end else if (handshake) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
            if ((state == ST_FLUSH) && (state_nxt == ST_IDLE)) begin
                sr_pc_q <= 1'b1;
            end
            sr_busy_q <= (state_nxt != ST_IDLE);
        end
    end

`ifdef ADC16DV160_CAPTURE_OVF_EN
    // Saturating count of RUN cycles spent with the sample FIFO full.
    logic [15:0] ovf_q;
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ovf_q <= 16'd0;
        end else if (go) begin
            ovf_q <= 16'd0;
        end else if ((state == ST_RUN) && fifo_full && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end
    assign ovf_cnt = ovf_q;
`else
    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;
`endif

    assign m00_axis.tvalid = tvalid_q;
    assign m00_axis.tdata  = tdata_q;
    assign m00_axis.tlast  = tlast_q;
    assign m00_axis.tkeep  = {KW{1'b1}};
    assign sr_busy         = sr_busy_q;
    assign sr_pc           = sr_pc_q;

endmodule

// File: tb/tb_adc16dv160_capture_ctrl.sv
module tb_adc16dv160_capture_ctrl;

    localparam int unsigned DW = 32;

    logic          ACLK;
    logic          ARESETN;
    logic          start;
    logic          test;
    logic [31:0]   dsize;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_rd_en;
    logic          sr_busy;
    logic          sr_pc;
`ifdef ADC16DV160_CAPTURE_OVF_EN
    logic [15:0]   ovf_cnt;
`endif

    adc16dv160_capture_ctrl_if #(.DW(DW)) axis ();

    adc16dv160_capture_ctrl #(.DW(DW)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .start      (start),
        .test       (test),
        .dsize      (dsize),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_rd_en (fifo_rd_en),
        .m00_axis   (axis),
        .sr_busy    (sr_busy),
`ifdef ADC16DV160_CAPTURE_OVF_EN
        .ovf_cnt    (ovf_cnt),
`endif
        .sr_pc      (sr_pc)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        start;
        logic        test;
        logic [31:0] dsize;
        logic        tready;
        logic        fifo_empty;
        logic        exp_tvalid;
        logic [31:0] exp_tdata;
        logic        exp_tlast;
        logic        exp_busy;
        logic        exp_pc;
        logic        exp_rd;
        logic        chk_data;
    } vec_t;

    // FIFO model and beat observer state.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] obs_data[$];
    logic          obs_last[$];
    int            obs_cyc[$];
    int            pop_cyc[$];
    int            cyc = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int            restart_at = -1;

    task automatic clear_obs();
        obs_data.delete(); obs_last.delete(); obs_cyc.delete(); pop_cyc.delete();
        prev_stall = 0;
    endtask

    task automatic refresh_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() == 0) ? '0 : fq[0];
    endtask

    // One clock: observe at the falling edge, then apply pops just after the rising edge.
    task automatic tick();
        bit popped;
        @(negedge ACLK);
        popped = fifo_rd_en;
        if (fifo_empty) chk("pop_when_empty", 64'(fifo_rd_en), 64'd0);
        if (prev_stall) begin
            chk("hold_tvalid", 64'(axis.tvalid), 64'd1);
            chk("hold_tdata", 64'(axis.tdata), 64'(prev_data));
            chk("hold_tlast", 64'(axis.tlast), 64'(prev_last));
        end
        prev_stall = axis.tvalid && !axis.tready;
        prev_data  = axis.tdata;
        prev_last  = axis.tlast;
        if (axis.tvalid && axis.tready) begin
            obs_data.push_back(axis.tdata);
            obs_last.push_back(axis.tlast);
            obs_cyc.push_back(cyc);
        end
        if (popped) pop_cyc.push_back(cyc);
        @(posedge ACLK);
        #1;
        cyc++;
        if (popped && fq.size() != 0) void'(fq.pop_front());
        refresh_fifo();
    endtask

    task automatic pulse_start(input logic t, input logic [31:0] n);
        start = 1'b1; test = t; dsize = n;
        tick();
        start = 1'b0;
    endtask

    // Run until the packet completes; mode 1 toggles tready each cycle.
    task automatic run_packet(input bit toggle, input int max_cyc);
        int  k = 0;
        bit  done = 0;
        while (!done && k < max_cyc) begin
            if (toggle) axis.tready = (k % 2 == 0);
            if (restart_at >= 0 && obs_data.size() == restart_at) begin
                start = 1'b1; dsize = 32'd2; restart_at = -1;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
            done = sr_pc && !sr_busy;
        end
        start = 1'b0;
        if (!done) chk("packet_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_beats(input string name, input int n, input logic [31:0] base);
        chk({name, "_count"}, 64'(obs_data.size()), 64'(n));
        for (int i = 0; i < obs_data.size() && i < n; i++) begin
            chk({name, "_data"}, 64'(obs_data[i]), 64'(base + 32'(i)));
            chk({name, "_last"}, 64'(obs_last[i]), 64'(i == n - 1));
        end
    endtask

    vec_t vecs[9];

    initial begin
        // Test-pattern packet of 4 beats, then an ignored zero-length start.
        vecs[0] = '{1'b1, 1'b1, 32'd4, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'd4, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'd4, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'd4, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'd4, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'd4, 1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'd4, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        ARESETN = 1'b0; start = 1'b0; test = 1'b0; dsize = 32'd0;
        fifo_full = 1'b0; axis.tready = 1'b1;
        refresh_fifo();
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("rst_tdata", 64'(axis.tdata), 64'd0);
        chk("rst_tlast", 64'(axis.tlast), 64'd0);
        chk("rst_busy", 64'(sr_busy), 64'd0);
        chk("rst_pc", 64'(sr_pc), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        ARESETN = 1'b1;

        for (int i = 0; i < 9; i++) begin
            start = vecs[i].start; test = vecs[i].test; dsize = vecs[i].dsize;
            axis.tready = vecs[i].tready; fifo_empty = vecs[i].fifo_empty;
            @(negedge ACLK);
            chk($sformatf("vec%0d_tvalid", i), 64'(axis.tvalid), 64'(vecs[i].exp_tvalid));
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_tdata", i), 64'(axis.tdata), 64'(vecs[i].exp_tdata));
            chk($sformatf("vec%0d_tlast", i), 64'(axis.tlast), 64'(vecs[i].exp_tlast));
            chk($sformatf("vec%0d_busy", i), 64'(sr_busy), 64'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_pc", i), 64'(sr_pc), 64'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_rd_en", i), 64'(fifo_rd_en), 64'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_tkeep", i), 64'(axis.tkeep), 64'h0F);
            @(posedge ACLK);
            #1;
        end
        start = 1'b0;
        refresh_fifo();

        // FIFO packet with tready toggling: 8 pops, data in order, held while stalled.
        clear_obs();
        for (int i = 0; i < 8; i++) fq.push_back(32'hA0 + 32'(i));
        refresh_fifo();
        pulse_start(1'b0, 32'd8);
        run_packet(1'b1, 80);
        check_beats("fifo8", 8, 32'hA0);
        chk("fifo8_pops", 64'(pop_cyc.size()), 64'd8);
        chk("fifo8_pc", 64'(sr_pc), 64'd1);
        axis.tready = 1'b1;

        // Full-rate FIFO packet: one-cycle pop latency and no bubbles.
        clear_obs();
        for (int i = 0; i < 6; i++) fq.push_back(32'h10 + 32'(i));
        refresh_fifo();
        pulse_start(1'b0, 32'd6);
        run_packet(1'b0, 40);
        check_beats("rate6", 6, 32'h10);
        if (obs_cyc.size() == 6 && pop_cyc.size() == 6) begin
            chk("rate6_span", 64'(obs_cyc[5] - obs_cyc[0]), 64'd5);
            chk("rate6_latency", 64'(obs_cyc[0] - pop_cyc[0]), 64'd1);
        end else begin
            chk("rate6_samples", 64'(pop_cyc.size()), 64'd6);
        end

        // Restart request mid-packet is ignored.
        clear_obs();
        restart_at = 5;
        pulse_start(1'b1, 32'd16);
        run_packet(1'b0, 60);
        check_beats("restart16", 16, 32'd0);
        restart_at = -1;

        // Reset mid-packet, then a fresh 2-beat packet from index 0.
        clear_obs();
        pulse_start(1'b1, 32'd10);
        for (int k = 0; k < 20 && obs_data.size() < 3; k++) tick();
        ARESETN = 1'b0;
        #1;
        chk("midrst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("midrst_busy", 64'(sr_busy), 64'd0);
        chk("midrst_tlast", 64'(axis.tlast), 64'd0);
        chk("midrst_rd_en", 64'(fifo_rd_en), 64'd0);
        tick(); tick();
        ARESETN = 1'b1;
        tick();
        chk("postrst_idle", 64'(sr_busy), 64'd0);
        clear_obs();
        pulse_start(1'b1, 32'd2);
        run_packet(1'b0, 20);
        check_beats("postrst2", 2, 32'd0);

        // Maximum length: no early tlast, then abandon via reset.
        clear_obs();
        pulse_start(1'b1, 32'hFFFF_FFFF);
        repeat (6) tick();
        chk("max_busy", 64'(sr_busy), 64'd1);
        chk("max_beats", 64'(obs_data.size()), 64'd5);
        chk("max_nolast", 64'(axis.tlast), 64'd0);
        ARESETN = 1'b0;
        tick();
        ARESETN = 1'b1;
        tick();

`ifdef ADC16DV160_CAPTURE_OVF_EN
        // Overflow counter: 5 full cycles in RUN, cleared by the next start.
        clear_obs();
        axis.tready = 1'b0;
        pulse_start(1'b1, 32'd2);
        fifo_full = 1'b1;
        repeat (5) tick();
        fifo_full = 1'b0;
        chk("ovf_count", 64'(ovf_cnt), 64'd5);
        axis.tready = 1'b1;
        run_packet(1'b0, 20);
        chk("ovf_hold", 64'(ovf_cnt), 64'd5);
        pulse_start(1'b1, 32'd1);
        chk("ovf_clear", 64'(ovf_cnt), 64'd0);
        run_packet(1'b0, 20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
